// File: rtl/uart_tx_engine.sv
// UART transmit engine: frames one byte (start, 7/8 data bits LSB first,
// optional parity, stop fill) and shifts it out on tx at baud_k clocks per bit.
module uart_tx_engine #(
  parameter int BAUD_W  = 19,
  parameter int FRAME_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        data_in,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              tx,
  output logic              tx_rdy,
  output logic              tx_done
);

  localparam int BIT_W = $clog2(FRAME_W + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] shift_reg;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BAUD_W-1:0]  baud_lim;
  logic [BIT_W-1:0]   bit_cnt;
  logic               accept;
  logic               term;
  logic               last;

  // Parity over the data bits actually sent; ohel=1 selects odd sense.
  function automatic logic calc_par(input logic [7:0] d, input logic e,
                                    input logic odd);
    logic [7:0] used;
    used = e ? d : {1'b0, d[6:0]};
    return (^used) ^ odd;
  endfunction

  // Frame image, bit 0 goes out first; positions past the frame send 1.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] d,
                                                      input logic e,
                                                      input logic p,
                                                      input logic odd);
    logic [FRAME_W-1:0] f;
    logic               par;
    f   = '1;
    par = calc_par(d, e, odd);
    f[0] = 1'b0;
    if (e) begin
      f[8:1] = d;
      f[9]   = p ? par : 1'b1;
    end else begin
      f[7:1] = d[6:0];
      f[8]   = p ? par : 1'b1;
    end
    return f;
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: accept a load when idle, return to idle after the last bit.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    term      = (state == SEND) && (baud_cnt == baud_lim - BAUD_W'(1));
    last      = term && (bit_cnt == BIT_W'(FRAME_W - 1));
    case (state)
      IDLE: begin
        if (load) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame latch, baud/bit counting, shifting and the registered line/done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= '1;
      baud_cnt  <= '0;
      baud_lim  <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= last;
      if (accept) begin
        shift_reg <= build_frame(data_in, eight, pen, ohel);
        baud_lim  <= baud_k;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        tx        <= 1'b0;
      end else if (state == SEND) begin
        if (term) begin
          baud_cnt  <= '0;
          shift_reg <= {1'b1, shift_reg[FRAME_W-1:1]};
          if (last) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            tx      <= shift_reg[1];
          end
        end else begin
          baud_cnt <= baud_cnt + BAUD_W'(1);
        end
      end
    end
  end

  assign tx_rdy = (state == IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed frames from the worked examples plus
// randomized frames checked against a queue-based frame model.
module tb_uart_tx_engine;

  localparam int BAUD_W  = 19;
  localparam int FRAME_W = 11;

  logic              clock;
  logic              reset;
  logic              load;
  logic [7:0]        data_in;
  logic              eight;
  logic              pen;
  logic              ohel;
  logic [BAUD_W-1:0] baud_k;
  logic              tx;
  logic              tx_rdy;
  logic              tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx_engine #(.BAUD_W(BAUD_W), .FRAME_W(FRAME_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .baud_k  (baud_k),
    .tx      (tx),
    .tx_rdy  (tx_rdy),
    .tx_done (tx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Line sequence built from the framing rules: start 0, data LSB first,
  // optional parity making the count of ones even (+ohel), then 1s to 11 bits.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                              input logic p, input logic o);
    logic       q[$];
    logic [10:0] f;
    int          n;
    int          ones;
    n    = e ? 8 : 7;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (p) q.push_back(((ones % 2) == 1) ^ o);
    while (q.size() < 11) q.push_back(1'b1);
    for (int i = 0; i < 11; i++) f[i] = q[i];
    return f;
  endfunction

  // Load a frame at the next edge and check tx/tx_rdy/tx_done every clock up
  // to and including the tx_done cycle. busy=1 adds an ignored load of 8'h00
  // mid-frame. Inputs are scrambled after the load edge.
  task automatic run_frame(input logic [7:0] d, input logic e, input logic p,
                           input logic o, input int k, input logic [10:0] exp,
                           input bit busy, input string tag);
    data_in = d; eight = e; pen = p; ohel = o; baud_k = BAUD_W'(k); load = 1'b1;
    tick();
    load    = 1'b0;
    data_in = 8'($urandom);
    eight   = 1'($urandom);
    pen     = 1'($urandom);
    ohel    = 1'($urandom);
    baud_k  = BAUD_W'($urandom_range(2, 7));
    for (int i = 0; i < 11 * k; i++) begin
      chk({tag, "_tx"}, tx, exp[i / k]);
      chk({tag, "_rdy"}, tx_rdy, 1'b0);
      chk({tag, "_done"}, tx_done, 1'b0);
      if (busy && i == 5 * k) begin
        load    = 1'b1;
        data_in = 8'h00;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    chk({tag, "_end_tx"}, tx, 1'b1);
    chk({tag, "_end_rdy"}, tx_rdy, 1'b1);
    chk({tag, "_end_done"}, tx_done, 1'b1);
  endtask

  initial begin
    logic [7:0] rd;
    logic       re, rp, ro;
    int         rk;

    reset = 1'b1; load = 1'b0; data_in = '0; eight = 1'b1; pen = 1'b0;
    ohel = 1'b0; baud_k = BAUD_W'(4);
    tick(); tick(); tick();
    chk("rst_tx", tx, 1'b1);
    chk("rst_rdy", tx_rdy, 1'b1);
    chk("rst_done", tx_done, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_tx", tx, 1'b1);
      chk("idle_rdy", tx_rdy, 1'b1);
      chk("idle_done", tx_done, 1'b0);
    end

    // 8'hA5, 8 bits, no parity, 4 clocks/bit: 0,1,0,1,0,0,1,0,1,1,1
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 4, 11'b11101001010, 1'b0, "a5");
    tick();
    chk("a5_done_pulse", tx_done, 1'b0);
    chk("a5_idle_tx", tx, 1'b1);

    // 8'h07, even parity -> parity bit 1
    run_frame(8'h07, 1'b1, 1'b1, 1'b0, 3, 11'b11000001110, 1'b0, "p07e");
    tick();
    // 8'h07, odd parity -> parity bit 0
    run_frame(8'h07, 1'b1, 1'b1, 1'b1, 3, 11'b10000001110, 1'b0, "p07o");
    tick();
    // 8'hFF, 7 bits, odd parity -> parity 0, then 1,1
    run_frame(8'hFF, 1'b0, 1'b1, 1'b1, 2, 11'b11011111110, 1'b0, "ff7");
    tick();

    // Busy load of 8'h00 ignored; then 8'hC3 loaded in the tx_done cycle.
    run_frame(8'h55, 1'b1, 1'b0, 1'b0, 3, model_frame(8'h55, 1'b1, 1'b0, 1'b0),
              1'b1, "busy55");
    run_frame(8'hC3, 1'b1, 1'b1, 1'b0, 3, model_frame(8'hC3, 1'b1, 1'b1, 1'b0),
              1'b0, "b2bC3");
    tick();
    chk("b2b_done_pulse", tx_done, 1'b0);

    // Reset during bit 5 of a frame.
    data_in = 8'h3C; eight = 1'b1; pen = 1'b1; ohel = 1'b0; baud_k = BAUD_W'(3);
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5 * 3 + 1; i++) tick();
    chk("pre_rst_rdy", tx_rdy, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_rdy", tx_rdy, 1'b1);
    chk("midrst_done", tx_done, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("postrst_tx", tx, 1'b1);
      chk("postrst_done", tx_done, 1'b0);
    end
    run_frame(8'h96, 1'b1, 1'b1, 1'b1, 4, model_frame(8'h96, 1'b1, 1'b1, 1'b1),
              1'b0, "afterrst");
    tick();

    // Randomized frames against the model, some chained back-to-back.
    for (int n = 0; n < 10; n++) begin
      rd = 8'($urandom);
      re = 1'($urandom);
      rp = 1'($urandom);
      ro = 1'($urandom);
      rk = int'($urandom_range(2, 6));
      run_frame(rd, re, rp, ro, rk, model_frame(rd, re, rp, ro), 1'($urandom),
                "rnd");
      if ($urandom_range(0, 1) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
